proc_bus_control: RTL and testbench
===================================

# proc_bus_control

Control unit for the nine-bit processor. It fetches a 9-bit instruction from DIN into an internal instruction register. It then sequences the bus-source selects (`r_out`, `g_out`, `DIN_out`) consumed by the bus multiplexer, along with the register-load enables (`r_in`, `a_in`, `g_in_en`) that write the bus back into R0–R7, A and G. It is the driving end of the bus-select interface: every cycle it names exactly one bus source (or none) and the destinations that capture it.

## Interface
Parameters:
- `OPW`, 3, opcode width (instruction bits [8:6]).
- `RW`, 3, register-field width (X = bits [5:3], Y = bits [2:0]).

Ports:
- `clock` in 1: single clock. All state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `run` in 1: start request, sampled only in state T0.
- `DIN` in 9: instruction word, captured into IR on fetch.
- `g_nz` in 1: G register is non-zero (from datapath); used by `mvnz`.
- `ir` out 9: current instruction register contents.
- `r_out` out 8: one-hot bus-source select for R0..R7.
- `g_out` out 1: G drives bus.
- `DIN_out` out 1: DIN drives bus.
- `r_in` out 8: one-hot load enable for R0..R7.
- `a_in` out 1: load A from bus.
- `g_in_en` out 1: load G from ALU result.
- `addsub` out 1: ALU op; 0 = A+bus, 1 = A−bus.
- `ir_in` out 1: IR load strobe (observable copy).
- `done` out 1: instruction completes this cycle.

## Operation
- Opcodes: 000 `mv` X←Y; 001 `mvi` X←DIN; 010 `add` X←X+Y; 011 `sub` X←X−Y; 100 `mvnz` X←Y if G≠0; 101–111 nop.
- States: T0, T1, T2, T3 (2-bit register). Control outputs are combinational from state and IR. IR is a register.
- T0:
  - If `run`=1: `ir_in`=1, IR←DIN at the edge, next state T1.
  - Otherwise all control outputs are 0 and the state stays T0.
- T1, by IR opcode:
  - `mv`: `r_out`=onehot(Y), `r_in`=onehot(X), `done`=1 → T0.
  - `mvi`: `DIN_out`=1, `r_in`=onehot(X), `done`=1 → T0. The immediate is the DIN word present in this cycle.
  - `add`/`sub`: `r_out`=onehot(X), `a_in`=1 → T2.
  - `mvnz`:
    - If `g_nz`: `r_out`=onehot(Y), `r_in`=onehot(X).
    - Otherwise `r_out`=0, `r_in`=0.
    - `done`=1 → T0 in both cases.
  - nop: `done`=1 with no enables → T0.
- T2 (`add`/`sub` only): `r_out`=onehot(Y), `g_in_en`=1, `addsub`=opcode[0] → T3.
- T3: `g_out`=1, `r_in`=onehot(X), `done`=1 → T0.
- Bus exclusivity, checked as an invariant: in every cycle, popcount(`r_out`) + `g_out` + `DIN_out` ≤ 1. `r_in` is zero or one-hot.
- X=Y is legal. Example: `add R2,R2` drives R2 in T1 and T2 and loads R2 in T3.

## Timing
- Reset (synchronous): state←T0, IR←0. At the reset edge's following cycle, every output is 0 (`ir`=0, `done`=0), unless `run`=1 then, which is a legal fetch.
- Reset asserted in T1–T3: the operation aborts at that edge with no `done`. Enables already issued in earlier cycles are not retracted.
- Latency from `run` sampled in T0:
  - `mv`/`mvi`/`mvnz`/nop: `done` one cycle later, 2 cycles total.
  - `add`/`sub`: `done` three cycles later, 4 cycles total.
- `run` is ignored in T1–T3. It is level-sensitive in T0: holding it high gives back-to-back fetches with no idle cycle after `done`.
- DIN must hold the instruction during the T0 fetch cycle. For `mvi`, DIN must hold the immediate in T1.
- `g_nz` is sampled combinationally in T1 of `mvnz`.

## Test plan
- Reset: assert `reset` 2 cycles with `run`=0 → all outputs 0 and state T0. Assert `reset` during T2 of `add` → next cycle T0, `done` never pulses.
- `mvi R3`: DIN=9'b001_011_000, `run`=1, then DIN=9'h0A5 → cycle 1 `ir_in`=1; cycle 2 `DIN_out`=1, `r_in`=8'h08, `done`=1.
- `mv R7,R0`: DIN=9'b000_111_000 → T1 `r_out`=8'h01, `r_in`=8'h80, `done`=1. The following cycle returns to idle zeros when `run`=0.
- `sub R1,R5`: DIN=9'b011_001_101 → T1 `r_out`=8'h02, `a_in`=1; T2 `r_out`=8'h20, `g_in_en`=1, `addsub`=1; T3 `g_out`=1, `r_in`=8'h02, `done`=1.
- `mvnz R4,R6`: run once with `g_nz`=0 → `r_in`=0, `done`=1. Run again with `g_nz`=1 → `r_out`=8'h40, `r_in`=8'h10.
- Back-to-back: `run` held high across `mv`, `add`, opcode 111 → fetches with no gap; nop gives `done` with all enables 0. The bus-exclusivity assertion holds every cycle.

Source files
------------

// File: rtl/proc_bus_control.sv
// Nine-bit processor control unit: fetches into IR and sequences
// bus-source selects and register-load enables over T0..T3.
module proc_bus_control #(
  parameter int OPW = 3,
  parameter int RW  = 3,
  localparam int IW = OPW + 2 * RW,
  localparam int NR = 1 << RW
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          run,
  input  logic [IW-1:0] DIN,
  input  logic          g_nz,
  output logic [IW-1:0] ir,
  output logic [NR-1:0] r_out,
  output logic          g_out,
  output logic          DIN_out,
  output logic [NR-1:0] r_in,
  output logic          a_in,
  output logic          g_in_en,
  output logic          addsub,
  output logic          ir_in,
  output logic          done
);

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  localparam logic [OPW-1:0] OP_MV   = OPW'(0);
  localparam logic [OPW-1:0] OP_MVI  = OPW'(1);
  localparam logic [OPW-1:0] OP_ADD  = OPW'(2);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(3);
  localparam logic [OPW-1:0] OP_MVNZ = OPW'(4);

  state_t state;
  state_t next;

  logic [OPW-1:0] op;
  logic [RW-1:0]  fx;
  logic [RW-1:0]  fy;
  logic [NR-1:0]  x_oh;
  logic [NR-1:0]  y_oh;

  assign op   = ir[IW-1 -: OPW];
  assign fx   = ir[2*RW-1 -: RW];
  assign fy   = ir[RW-1:0];
  assign x_oh = NR'(1) << fx;
  assign y_oh = NR'(1) << fy;

  always_comb begin
    next    = state;
    r_out   = '0;
    g_out   = 1'b0;
    DIN_out = 1'b0;
    r_in    = '0;
    a_in    = 1'b0;
    g_in_en = 1'b0;
    addsub  = 1'b0;
    ir_in   = 1'b0;
    done    = 1'b0;
    unique case (state)
      T0: begin
        if (run) begin
          ir_in = 1'b1;
          next  = T1;
        end
      end
      T1: begin
        next = T0;
        done = 1'b1;
        unique case (op)
          OP_MV: begin
            r_out = y_oh;
            r_in  = x_oh;
          end
          OP_MVI: begin
            DIN_out = 1'b1;
            r_in    = x_oh;
          end
          OP_ADD, OP_SUB: begin
            r_out = x_oh;
            a_in  = 1'b1;
            done  = 1'b0;
            next  = T2;
          end
          OP_MVNZ: begin
            if (g_nz) begin
              r_out = y_oh;
              r_in  = x_oh;
            end
          end
          default: ;
        endcase
      end
      T2: begin
        r_out   = y_oh;
        g_in_en = 1'b1;
        addsub  = op[0];
        next    = T3;
      end
      T3: begin
        g_out = 1'b1;
        r_in  = x_oh;
        done  = 1'b1;
        next  = T0;
      end
      default: next = T0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= T0;
      ir    <= '0;
    end else begin
      state <= next;
      if (ir_in) ir <= DIN;
    end
  end

endmodule

// File: tb/tb_proc_bus_control.sv
// Self-checking bench for proc_bus_control: directed cases plus
// random traffic against a per-instruction step-script model.
module tb_proc_bus_control;

  logic       clock = 1'b0;
  logic       reset;
  logic       run;
  logic [8:0] DIN;
  logic       g_nz;
  logic [8:0] ir;
  logic [7:0] r_out;
  logic       g_out;
  logic       DIN_out;
  logic [7:0] r_in;
  logic       a_in;
  logic       g_in_en;
  logic       addsub;
  logic       ir_in;
  logic       done;

  proc_bus_control dut (
    .clock   (clock),
    .reset   (reset),
    .run     (run),
    .DIN     (DIN),
    .g_nz    (g_nz),
    .ir      (ir),
    .r_out   (r_out),
    .g_out   (g_out),
    .DIN_out (DIN_out),
    .r_in    (r_in),
    .a_in    (a_in),
    .g_in_en (g_in_en),
    .addsub  (addsub),
    .ir_in   (ir_in),
    .done    (done)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0] r_out;
    logic       g_out;
    logic       din_out;
    logic [7:0] r_in;
    logic       a_in;
    logic       g_in_en;
    logic       addsub;
    logic       ir_in;
    logic       done;
  } bus_t;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: IR copy plus a script of remaining execute steps.
  logic [8:0] m_ir;
  int         m_q[$];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)",
               tag, obs, exp, $time);
    end
  endtask

  function automatic bus_t exp_step(input logic [8:0] ins,
                                    input int step,
                                    input logic gnz);
    bus_t e;
    int   op, x, y;
    e  = '0;
    op = int'(ins[8:6]);
    x  = int'(ins[5:3]);
    y  = int'(ins[2:0]);
    if (step == 0) begin
      case (op)
        0: begin
          e.r_out = 8'(1 << y);
          e.r_in  = 8'(1 << x);
          e.done  = 1'b1;
        end
        1: begin
          e.din_out = 1'b1;
          e.r_in    = 8'(1 << x);
          e.done    = 1'b1;
        end
        2, 3: begin
          e.r_out = 8'(1 << x);
          e.a_in  = 1'b1;
        end
        4: begin
          if (gnz) begin
            e.r_out = 8'(1 << y);
            e.r_in  = 8'(1 << x);
          end
          e.done = 1'b1;
        end
        default: e.done = 1'b1;
      endcase
    end else if (step == 1) begin
      e.r_out   = 8'(1 << y);
      e.g_in_en = 1'b1;
      e.addsub  = (op == 3);
    end else begin
      e.g_out = 1'b1;
      e.r_in  = 8'(1 << x);
      e.done  = 1'b1;
    end
    return e;
  endfunction

  task automatic cyc(input logic rst, input logic rn,
                     input logic [8:0] din, input logic gnz);
    bus_t e, o;
    int   nsteps;
    @(negedge clock);
    reset = rst;
    run   = rn;
    DIN   = din;
    g_nz  = gnz;
    #1;
    if (m_q.size() == 0) begin
      e       = '0;
      e.ir_in = rn;
    end else begin
      e = exp_step(m_ir, m_q[0], gnz);
    end
    o = '{r_out, g_out, DIN_out, r_in, a_in,
          g_in_en, addsub, ir_in, done};
    chk("outs", 32'(o), 32'(e));
    chk("ir", 32'(ir), 32'(m_ir));
    chk("bus_excl",
        32'(($countones(r_out) + int'(g_out) + int'(DIN_out)) <= 1),
        32'd1);
    chk("rin_onehot0", 32'($onehot0(r_in)), 32'd1);
    @(posedge clock);
    if (rst) begin
      m_q.delete();
      m_ir = '0;
    end else if (m_q.size() == 0) begin
      if (rn) begin
        m_ir   = din;
        nsteps = (din[8:6] == 3'd2 || din[8:6] == 3'd3) ? 3 : 1;
        for (int i = 0; i < nsteps; i++) m_q.push_back(i);
      end
    end else begin
      void'(m_q.pop_front());
    end
  endtask

  initial begin
    reset = 1'b1;
    run   = 1'b0;
    DIN   = '0;
    g_nz  = 1'b0;
    m_ir  = '0;
    @(posedge clock);
    cyc(1, 0, 9'h000, 0);
    cyc(1, 0, 9'h000, 0);
    cyc(0, 0, 9'h1FF, 1);
    // mvi R3 with immediate 0x0A5
    cyc(0, 1, 9'b001_011_000, 0);
    cyc(0, 0, 9'h0A5, 0);
    // mv R7,R0 then idle
    cyc(0, 1, 9'b000_111_000, 0);
    cyc(0, 0, 9'h000, 0);
    cyc(0, 0, 9'h000, 0);
    // sub R1,R5
    cyc(0, 1, 9'b011_001_101, 0);
    cyc(0, 0, 9'h000, 0);
    cyc(0, 0, 9'h000, 0);
    cyc(0, 0, 9'h000, 0);
    // mvnz R4,R6 with g_nz low then high
    cyc(0, 1, 9'b100_100_110, 1);
    cyc(0, 0, 9'h000, 0);
    cyc(0, 1, 9'b100_100_110, 0);
    cyc(0, 0, 9'h000, 1);
    // add R2,R2 aborted by reset in T2
    cyc(0, 1, 9'b010_010_010, 0);
    cyc(0, 0, 9'h000, 0);
    cyc(1, 0, 9'h000, 0);
    cyc(0, 0, 9'h000, 0);
    // back-to-back: mv, add, nop with run held
    cyc(0, 1, 9'b000_001_010, 0);
    cyc(0, 1, 9'h1FF, 0);
    cyc(0, 1, 9'b010_011_100, 0);
    cyc(0, 1, 9'h1FF, 0);
    cyc(0, 1, 9'h1FF, 0);
    cyc(0, 1, 9'h1FF, 0);
    cyc(0, 1, 9'b111_101_011, 0);
    cyc(0, 1, 9'h000, 0);
    cyc(0, 0, 9'h000, 0);
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 29) == 0),
          1'($urandom),
          9'($urandom),
          1'($urandom));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
